hex_sr_host: RTL and testbench
==============================

Name: hex_sr_host

Overview:
- Host-side controller for the hex shift-register chip.
- Generates the chip's shift clock, recirculate select and 6-bit input digit. Samples the chip's 6-bit output digit.
- Load mode: writes a frame of LENGTH digits from a valid/ready stream.
- Read mode: returns LENGTH digits on a valid/ready stream while recirculating, so the frame is preserved. Lives in the FPGA/test-harness fabric that drives the chip pins.

Parameters:
- LENGTH, 55, shift-register depth in digits; frame size for load and read.
- CLK_DIV, 2, sr_clk half-period in clk cycles; must be >=1 (>=3 when HEX_SR_HOST_SYNC_EN is defined).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_load  in  1  one-cycle request to write a frame
- start_read  in  1  one-cycle request to read a frame
- busy  out  1  high while any operation is in progress
- done  out  1  one-cycle pulse when an operation completes
- in_data  in  6  digit to write
- in_valid  in  1  in_data valid
- in_ready  out  1  digit accepted when in_valid & in_ready
- out_data  out  6  digit read back
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- sr_clk  out  1  chip shift clock; chip shifts on its rising edge
- sr_recirc  out  1  chip recirculate select (1 = chip output fed back to its input)
- sr_din  out  6  chip input digit
- sr_dout  in  6  chip output digit (oldest stored digit)

Behaviour:
- Reset: all outputs 0, state IDLE, digit counter cnt=0. rst mid-operation aborts immediately, with sr_clk low on the next cycle. The chip frame is then undefined and the host must reload.
- States: IDLE, W_WAIT, W_LO, W_HI, R_LO, R_WAIT, R_HI.
- IDLE: busy=0.
  - start_load -> W_WAIT, cnt=0, sr_recirc=0.
  - Otherwise start_read -> R_LO, cnt=0, sr_recirc=1.
  - Both asserted together: load wins.
  - start_* while busy is ignored.
- W_WAIT: in_ready=1.
  - On handshake: latch in_data into sr_din, in_ready=0 next cycle -> W_LO.
- W_LO: sr_clk=0 for CLK_DIV cycles, giving data setup -> W_HI.
- W_HI: sr_clk=1 for CLK_DIV cycles, then sr_clk=0.
  - If cnt==LENGTH-1: done pulse, -> IDLE.
  - Otherwise cnt++ -> W_WAIT.
  - sr_din is held until the next handshake.
- R_LO: sr_clk=0 for CLK_DIV cycles. On the last cycle, sample sr_dout into out_data and set out_valid=1 -> R_WAIT.
- R_WAIT: hold out_data and out_valid until out_ready.
  - On handshake, out_valid=0 -> R_HI.
  - No sr_clk edge occurs until the digit is consumed, so backpressure is lossless.
- R_HI: sr_clk=1 for CLK_DIV cycles; the chip rotates one digit.
  - cnt==LENGTH-1: done pulse, sr_recirc=0, -> IDLE.
  - Otherwise cnt++ -> R_LO.
- sr_din is driven 0 throughout a read.
- Ordering:
  - Digits come out in the order written; the first written is read first.
  - After a full read the chip holds the identical frame, and consecutive reads return the same sequence.
- Timing:
  - One sr_clk period is 2*CLK_DIV clk cycles, plus handshake stalls.
  - Minimum load frame time is LENGTH*(2*CLK_DIV+1) cycles with in_valid held high.
- cnt width is clog2(LENGTH); it never wraps past LENGTH-1.
- sr_clk is a registered output: glitch-free, and only changes in the LO/HI phase transitions.

Optional Feature:
- Macro HEX_SR_HOST_SYNC_EN.
- When defined: sr_dout passes through a 2-flop synchronizer before sampling. The R_LO sample point is unchanged, but it uses the synchronized value, and CLK_DIV>=3 is required. Elaboration-time error if violated.
- When undefined: sr_dout is sampled directly, and the chip is assumed to be in the same clock domain.

Decomposition:
- Shared package hex_sr_pkg:
  - DIGIT_W=6.
  - State enum type for the above states.
  - Default LENGTH constant, shared with the shift-register block.
- One sub-module, hex_sr_clkgen: phase counter producing sr_clk plus phase_end strobes.
- The FSM and data path stay in hex_sr_host.

Test Plan (LENGTH=4, CLK_DIV=2 unless noted; bench includes a behavioural 4-deep hex SR model):
- Load 0x01,0x02,0x03,0x04 with in_valid always high -> exactly 4 sr_clk rising edges; done pulses once after the 4th high phase; model holds 01..04.
- After that load, start_read with out_ready=1 -> out_data sequence 0x01,0x02,0x03,0x04. A second read returns the same sequence.
- Read with out_ready low for 10 cycles per digit -> sr_clk stays low while out_valid is high; no digit is lost or duplicated.
- start_load and start_read in the same cycle -> a load is performed. start_read pulsed mid-load -> ignored, busy stays 1.
- rst asserted during the 2nd write digit -> the next cycle shows sr_clk=0, busy=0, in_ready=0, out_valid=0. A fresh load/read of 0x3F,0x00,0x2A,0x15 round-trips exactly.
- With HEX_SR_HOST_SYNC_EN, CLK_DIV=3 -> the read sequence matches the written frame.

Source files
------------

// File: rtl/hex_sr_pkg.sv
// Shared types and constants for the hex shift-register host and the chip model it drives.
package hex_sr_pkg;

  localparam int unsigned DIGIT_W        = 6;
  localparam int unsigned DEFAULT_LENGTH = 55;

  typedef enum logic [2:0] {
    StIdle,
    StWWait,
    StWLo,
    StWHi,
    StRLo,
    StRWait,
    StRHi
  } state_e;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_sr_clkgen.sv
// Phase counter for the chip shift clock: times each LO/HI phase and owns the sr_clk flop.
module hex_sr_clkgen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic rise_i,
  input  logic fall_i,
  output logic sr_clk_o,
  output logic phase_end_o
);

  localparam int unsigned PhW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PhW-1:0] PhLast = PhW'(CLK_DIV - 1);

  logic [PhW-1:0] ph_q, ph_d;
  logic           sr_clk_q, sr_clk_d;

  assign phase_end_o = en_i && (ph_q == PhLast);
  assign sr_clk_o    = sr_clk_q;

  always_comb begin
    ph_d = ph_q;
    if (!en_i || phase_end_o) begin
      ph_d = '0;
    end else begin
      ph_d = ph_q + 1'b1;
    end
  end

  always_comb begin
    sr_clk_d = sr_clk_q;
    if (rise_i) begin
      sr_clk_d = 1'b1;
    end else if (fall_i) begin
      sr_clk_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ph_q     <= '0;
      sr_clk_q <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      sr_clk_q <= sr_clk_d;
    end
  end

endmodule

// File: rtl/hex_sr_host.sv
// Host controller for the hex shift-register chip: frame load and non-destructive frame read.
// Optional HEX_SR_HOST_SYNC_EN adds a 2-flop synchronizer on sr_dout.
module hex_sr_host
  import hex_sr_pkg::*;
#(
  parameter int unsigned LENGTH  = DEFAULT_LENGTH,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_load,
  input  logic               start_read,
  output logic               busy,
  output logic               done,
  input  logic [DIGIT_W-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DIGIT_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sr_clk,
  output logic               sr_recirc,
  output logic [DIGIT_W-1:0] sr_din,
  input  logic [DIGIT_W-1:0] sr_dout
);

  localparam int unsigned    CntW    = cnt_width(LENGTH);
  localparam logic [CntW-1:0] CntLast = CntW'(LENGTH - 1);

  if (CLK_DIV < 1) begin : gen_div_chk
    $error("hex_sr_host: CLK_DIV must be >= 1");
  end
  if (LENGTH < 1) begin : gen_len_chk
    $error("hex_sr_host: LENGTH must be >= 1");
  end

  logic [DIGIT_W-1:0] dout_s;

`ifdef HEX_SR_HOST_SYNC_EN
  if (CLK_DIV < 3) begin : gen_sync_div_chk
    $error("hex_sr_host: CLK_DIV must be >= 3 with HEX_SR_HOST_SYNC_EN");
  end

  logic [DIGIT_W-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sr_dout;
      sync2_q <= sync1_q;
    end
  end

  assign dout_s = sync2_q;
`else
  assign dout_s = sr_dout;
`endif

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [DIGIT_W-1:0] out_data_q, out_data_d;
  logic               sr_recirc_q, sr_recirc_d;
  logic [DIGIT_W-1:0] sr_din_q, sr_din_d;

  logic ph_en, ph_end, clk_rise, clk_fall;

  assign ph_en = (state_q == StWLo) || (state_q == StWHi) ||
                 (state_q == StRLo) || (state_q == StRHi);

  hex_sr_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (ph_en),
    .rise_i      (clk_rise),
    .fall_i      (clk_fall),
    .sr_clk_o    (sr_clk),
    .phase_end_o (ph_end)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sr_recirc_d = sr_recirc_q;
    sr_din_d    = sr_din_q;
    clk_rise    = 1'b0;
    clk_fall    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_load) begin
          state_d     = StWWait;
          cnt_d       = '0;
          busy_d      = 1'b1;
          in_ready_d  = 1'b1;
          sr_recirc_d = 1'b0;
        end else if (start_read) begin
          state_d     = StRLo;
          cnt_d       = '0;
          busy_d      = 1'b1;
          sr_recirc_d = 1'b1;
          sr_din_d    = '0;
        end
      end

      StWWait: begin
        if (in_valid && in_ready_q) begin
          sr_din_d   = in_data;
          in_ready_d = 1'b0;
          state_d    = StWLo;
        end
      end

      // Full low phase before the rising edge gives the chip data setup time.
      StWLo: begin
        if (ph_end) begin
          clk_rise = 1'b1;
          state_d  = StWHi;
        end
      end

      StWHi: begin
        if (ph_end) begin
          clk_fall = 1'b1;
          if (cnt_q == CntLast) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            cnt_d      = cnt_q + 1'b1;
            in_ready_d = 1'b1;
            state_d    = StWWait;
          end
        end
      end

      StRLo: begin
        if (ph_end) begin
          out_data_d  = dout_s;
          out_valid_d = 1'b1;
          state_d     = StRWait;
        end
      end

      // The chip is not clocked until the digit is consumed, so stalls lose nothing.
      StRWait: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          clk_rise    = 1'b1;
          state_d     = StRHi;
        end
      end

      StRHi: begin
        if (ph_end) begin
          clk_fall = 1'b1;
          if (cnt_q == CntLast) begin
            done_d      = 1'b1;
            busy_d      = 1'b0;
            sr_recirc_d = 1'b0;
            state_d     = StIdle;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StRLo;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sr_recirc_q <= 1'b0;
      sr_din_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sr_recirc_q <= sr_recirc_d;
      sr_din_q    <= sr_din_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sr_recirc = sr_recirc_q;
  assign sr_din    = sr_din_q;

endmodule

// File: tb/tb_hex_sr_host.sv
// Bench for hex_sr_host with a behavioural 4-deep hex shift-register chip model.
module tb_hex_sr_host;

  localparam int L = 4;
`ifdef HEX_SR_HOST_SYNC_EN
  localparam int CD = 3;
`else
  localparam int CD = 2;
`endif
  localparam int BOUND = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_load, start_read;
  logic       busy, done;
  logic [5:0] in_data;
  logic       in_valid, in_ready;
  logic [5:0] out_data;
  logic       out_valid, out_ready;
  logic       sr_clk, sr_recirc;
  logic [5:0] sr_din, sr_dout;

  always #5 clk = ~clk;

  hex_sr_host #(
    .LENGTH  (L),
    .CLK_DIV (CD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_load (start_load),
    .start_read (start_read),
    .busy       (busy),
    .done       (done),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sr_clk     (sr_clk),
    .sr_recirc  (sr_recirc),
    .sr_din     (sr_din),
    .sr_dout    (sr_dout)
  );

  // Chip model: on each rising sr_clk the oldest digit leaves; the new tail is either
  // the leaving digit (recirculate) or sr_din.
  logic [5:0] chip [L];
  int rise_cnt = 0;
  always @(posedge sr_clk) begin
    for (int i = 0; i < L - 1; i++) chip[i] <= chip[i+1];
    chip[L-1] <= sr_recirc ? chip[0] : sr_din;
    rise_cnt  <= rise_cnt + 1;
  end
  assign sr_dout = chip[0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0;
  int stall_err = 0;
  int din_err = 0;
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (out_valid && sr_clk) stall_err <= stall_err + 1;
    if (sr_recirc && sr_din != 6'h00) din_err <= din_err + 1;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic write_digit(input logic [5:0] d, input bit gaps, input string tag);
    int t = 0;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    if (t >= BOUND) check({tag, "_wr_timeout"}, 32'(t < BOUND), 1);
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!done && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_seen"}, 32'(done), 1);
  endtask

  task automatic load_frame(input logic [5:0] d [L], input bit gaps, input bit both,
                            input bit mid_read, input string tag);
    int r0, d0, t0;
    r0 = rise_cnt;
    d0 = done_cnt;
    start_load = 1'b1;
    start_read = both;
    @(negedge clk);
    start_load = 1'b0;
    start_read = 1'b0;
    t0 = cyc;
    check({tag, "_busy"}, 32'(busy), 1);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_recirc"}, 32'(sr_recirc), 0);
    for (int i = 0; i < L; i++) begin
      write_digit(d[i], gaps, tag);
      if (mid_read && i == 1) begin
        start_read = 1'b1;
        @(negedge clk);
        start_read = 1'b0;
        @(negedge clk);
        check({tag, "_mid_busy"}, 32'(busy), 1);
        check({tag, "_mid_recirc"}, 32'(sr_recirc), 0);
      end
    end
    wait_done(tag);
    if (!gaps && !mid_read) check({tag, "_time"}, 32'(cyc - t0), 32'(L * (2 * CD + 1)));
    check({tag, "_clk_low"}, 32'(sr_clk), 0);
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_rises"}, 32'(rise_cnt - r0), 32'(L));
    check({tag, "_dones"}, 32'(done_cnt - d0), 1);
    check({tag, "_idle"}, 32'(busy), 0);
    for (int i = 0; i < L; i++) check($sformatf("%s_chip%0d", tag, i), 32'(chip[i]), 32'(d[i]));
  endtask

  task automatic read_frame(input logic [5:0] d [L], input int slo, input int shi,
                            input bit hold, input string tag);
    int r0, d0, s0, n0, t;
    r0 = rise_cnt;
    d0 = done_cnt;
    s0 = stall_err;
    n0 = din_err;
    out_ready  = hold;
    start_read = 1'b1;
    @(negedge clk);
    start_read = 1'b0;
    check({tag, "_busy"}, 32'(busy), 1);
    check({tag, "_recirc"}, 32'(sr_recirc), 1);
    for (int i = 0; i < L; i++) begin
      t = 0;
      while (!out_valid && t < BOUND) begin
        @(negedge clk);
        t++;
      end
      if (t >= BOUND) check({tag, "_rd_timeout"}, 32'(t < BOUND), 1);
      if (!hold) begin
        repeat ($urandom_range(shi, slo)) @(negedge clk);
        check($sformatf("%s_v%0d", tag, i), 32'(out_valid), 1);
        out_ready = 1'b1;
      end
      check($sformatf("%s_d%0d", tag, i), 32'(out_data), 32'(d[i]));
      @(negedge clk);
      if (!hold) out_ready = 1'b0;
    end
    wait_done(tag);
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_rises"}, 32'(rise_cnt - r0), 32'(L));
    check({tag, "_dones"}, 32'(done_cnt - d0), 1);
    check({tag, "_no_clk_while_valid"}, 32'(stall_err - s0), 0);
    check({tag, "_din_zero"}, 32'(din_err - n0), 0);
    check({tag, "_recirc_off"}, 32'(sr_recirc), 0);
    check({tag, "_no_extra"}, 32'(out_valid), 0);
    for (int i = 0; i < L; i++) check($sformatf("%s_keep%0d", tag, i), 32'(chip[i]), 32'(d[i]));
  endtask

  task automatic rand_frame(output logic [5:0] d [L]);
    for (int i = 0; i < L; i++) d[i] = 6'($urandom_range(63, 0));
  endtask

  logic [5:0] f [L];

  initial begin
    rst        = 1'b1;
    start_load = 1'b0;
    start_read = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_sr_clk", 32'(sr_clk), 0);
    check("rst_recirc", 32'(sr_recirc), 0);
    check("rst_din", 32'(sr_din), 0);
    rst = 1'b0;
    @(negedge clk);

    f = '{6'h01, 6'h02, 6'h03, 6'h04};
    load_frame(f, 1'b0, 1'b0, 1'b0, "ld1");
    read_frame(f, 0, 0, 1'b1, "rd1");
    read_frame(f, 0, 0, 1'b1, "rd2");
    read_frame(f, 10, 10, 1'b0, "rdstall");

    rand_frame(f);
    load_frame(f, 1'b0, 1'b1, 1'b0, "both");
    read_frame(f, 0, 2, 1'b0, "rdboth");

    rand_frame(f);
    load_frame(f, 1'b1, 1'b0, 1'b1, "midrd");
    read_frame(f, 0, 0, 1'b1, "rdmid");

    // Abort during the second written digit, while sr_clk is high.
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    write_digit(6'h11, 1'b0, "abort");
    write_digit(6'h22, 1'b0, "abort");
    repeat (CD) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_sr_clk", 32'(sr_clk), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_in_ready", 32'(in_ready), 0);
    check("abort_out_valid", 32'(out_valid), 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    f = '{6'h3F, 6'h00, 6'h2A, 6'h15};
    load_frame(f, 1'b0, 1'b0, 1'b0, "ld2");
    read_frame(f, 0, 0, 1'b1, "rd3");

    for (int k = 0; k < 3; k++) begin
      rand_frame(f);
      load_frame(f, 1'b1, 1'b0, 1'b0, $sformatf("rld%0d", k));
      read_frame(f, 0, 4, 1'b0, $sformatf("rrd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
